// File: rtl/alu_seq_pkg.sv
// Shared op codes and FSM states for the sequential ALU.
// Imported by the datapath, the top and the bench.
package alu_seq_pkg;

  localparam logic [3:0] OP_NEGA = 4'b0000;
  localparam logic [3:0] OP_NEGB = 4'b0001;
  localparam logic [3:0] OP_ADD  = 4'b0010;
  localparam logic [3:0] OP_SUB  = 4'b0011;
  localparam logic [3:0] OP_AND  = 4'b0100;
  localparam logic [3:0] OP_OR   = 4'b0101;
  localparam logic [3:0] OP_XOR  = 4'b0110;
  localparam logic [3:0] OP_NOTA = 4'b0111;
  localparam logic [3:0] OP_MUL  = 4'b1000;
  localparam logic [3:0] OP_SHL  = 4'b1001;
  localparam logic [3:0] OP_SHR  = 4'b1010;
  localparam logic [3:0] OP_SAR  = 4'b1011;

  typedef enum logic [1:0] {
    S_IDLE = 2'b00,
    S_MUL  = 2'b01,
    S_DONE = 2'b10
  } state_t;

endpackage

// File: rtl/alu_core_comb.sv
// Single-cycle ALU datapath: (op, a, b) -> (r, carry, ovf, err).
// MUL is handled by the sequential top; here it yields zeros.
module alu_core_comb
  import alu_seq_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int SHW   = 3
) (
  input  logic [3:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] r,
  output logic             carry,
  output logic             ovf,
  output logic             err
);

  logic [WIDTH-1:0] ax;
  logic [WIDTH-1:0] by;
  logic             cin;
  logic [WIDTH:0]   sum;
  logic             add_ovf;
  logic [SHW-1:0]   s;
  logic [WIDTH:0]   shl_w;
  logic [WIDTH:0]   shr_w;
  logic [WIDTH:0]   sar_w;

  assign s = b[SHW-1:0];

  // Shared adder: 0/A plus B, A or a complement, plus cin.
  always_comb begin
    ax  = a;
    by  = b;
    cin = 1'b0;
    unique case (1'b1)
      op == OP_NEGA: begin
        ax  = '0;
        by  = ~a;
        cin = 1'b1;
      end
      op == OP_NEGB: begin
        ax  = '0;
        by  = ~b;
        cin = 1'b1;
      end
      op == OP_SUB: begin
        by  = ~b;
        cin = 1'b1;
      end
      default: ;
    endcase
  end

  assign sum = {1'b0, ax} + {1'b0, by}
             + {{WIDTH{1'b0}}, cin};

  assign add_ovf = (ax[WIDTH-1] == by[WIDTH-1])
                && (sum[WIDTH-1] != ax[WIDTH-1]);

  // Extra bit beside the operand catches the last bit shifted out.
  assign shl_w = {1'b0, a} << s;
  assign shr_w = {a, 1'b0} >> s;
  assign sar_w = $signed({a, 1'b0}) >>> s;

  always_comb begin
    r     = '0;
    carry = 1'b0;
    ovf   = 1'b0;
    err   = 1'b0;
    unique case (op)
      OP_NEGA, OP_NEGB, OP_ADD, OP_SUB: begin
        r     = sum[WIDTH-1:0];
        carry = sum[WIDTH];
        ovf   = add_ovf;
      end
      OP_AND:  r = a & b;
      OP_OR:   r = a | b;
      OP_XOR:  r = a ^ b;
      OP_NOTA: r = ~a;
      OP_MUL:  r = '0;
      OP_SHL: begin
        r     = shl_w[WIDTH-1:0];
        carry = shl_w[WIDTH];
      end
      OP_SHR: begin
        r     = shr_w[WIDTH:1];
        carry = shr_w[0];
      end
      OP_SAR: begin
        r     = sar_w[WIDTH:1];
        carry = sar_w[0];
      end
      default: err = 1'b1;
    endcase
  end

endmodule

// File: rtl/alu_seq.sv
// Registered ALU with valid/ready handshake and a WIDTH-step
// shift-add multiplier; result and flags held until taken.
module alu_seq
  import alu_seq_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int SHW   = 3
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [3:0]       op,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] R,
  output logic             zero,
  output logic             carry,
  output logic             sign,
  output logic             ovf,
  output logic             err
);

  localparam logic [SHW-1:0] LAST = SHW'(WIDTH - 1);

  state_t state_q, state_d;

  logic               accept;
  logic               load_alu;
  logic               load_mul;
  logic               start_mul;
  logic               ov_d;

  logic [WIDTH-1:0]   core_r;
  logic               core_c;
  logic               core_o;
  logic               core_e;

  logic [WIDTH-1:0]   mcand_q;
  logic [WIDTH-1:0]   mplier_q;
  logic [SHW-1:0]     cnt_q;
  logic [2*WIDTH-1:0] acc_q;
  logic [2*WIDTH-1:0] acc_d;
  logic [2*WIDTH-1:0] pp;
  logic               mul_hi;

  alu_core_comb #(
    .WIDTH (WIDTH),
    .SHW   (SHW)
  ) u_core (
    .op    (op),
    .a     (A),
    .b     (B),
    .r     (core_r),
    .carry (core_c),
    .ovf   (core_o),
    .err   (core_e)
  );

  assign pp     = {{WIDTH{1'b0}}, mplier_q} << cnt_q;
  assign acc_d  = mcand_q[0] ? acc_q + pp : acc_q;
  assign mul_hi = acc_d[2*WIDTH-1:WIDTH] != '0;
  assign sign   = R[WIDTH-1];

  always_comb begin
    state_d   = state_q;
    load_alu  = 1'b0;
    load_mul  = 1'b0;
    start_mul = 1'b0;
    ov_d      = out_valid;
    in_ready  = (state_q == S_IDLE)
             && (!out_valid || out_ready);
    accept    = in_valid && in_ready;
    unique case (state_q)
      S_IDLE: begin
        if (accept && op == OP_MUL) begin
          start_mul = 1'b1;
          ov_d      = 1'b0;
          state_d   = S_MUL;
        end else if (accept) begin
          load_alu  = 1'b1;
          ov_d      = 1'b1;
        end else if (out_ready) begin
          ov_d      = 1'b0;
        end
      end
      S_MUL: begin
        if (cnt_q == LAST) begin
          load_mul  = 1'b1;
          ov_d      = 1'b1;
          state_d   = S_DONE;
        end
      end
      S_DONE: begin
        if (out_ready) begin
          ov_d      = 1'b0;
          state_d   = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= S_IDLE;
      out_valid <= 1'b0;
    end else begin
      state_q   <= state_d;
      out_valid <= ov_d;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mcand_q  <= '0;
      mplier_q <= '0;
      cnt_q    <= '0;
      acc_q    <= '0;
    end else if (start_mul) begin
      mcand_q  <= A;
      mplier_q <= B;
      cnt_q    <= '0;
      acc_q    <= '0;
    end else if (state_q == S_MUL) begin
      mcand_q  <= mcand_q >> 1;
      cnt_q    <= cnt_q + 1'b1;
      acc_q    <= acc_d;
    end
  end

  // zero is registered so that it reads 0 out of reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      R     <= '0;
      zero  <= 1'b0;
      carry <= 1'b0;
      ovf   <= 1'b0;
      err   <= 1'b0;
    end else if (load_alu) begin
      R     <= core_r;
      zero  <= core_r == '0;
      carry <= core_c;
      ovf   <= core_o;
      err   <= core_e;
    end else if (load_mul) begin
      R     <= acc_d[WIDTH-1:0];
      zero  <= acc_d[WIDTH-1:0] == '0;
      carry <= mul_hi;
      ovf   <= mul_hi;
      err   <= 1'b0;
    end
  end

endmodule
